corefifo_sched: RTL

//  Access scheduler for the 4-deep, 38-bit core opcode FIFO (corefifo). Arbitrates
//  NUM_SRC opcode producers onto the FIFO write port and drains the read port into a

---
 rtl/corefifo_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 69 ++++++
 rtl/corefifo_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/corefifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : corefifo_pkg
//  Description : Shared types and constants for the core opcode FIFO and its
//                access scheduler.
//  Contents    : OPCODE_W   - opcode width carried by corefifo
//                FIFO_DEPTH - corefifo entry count
//                fifo_op_t  - FIFO port operation (read / write)
//                opcode_t   - one opcode word
//  Revision    : 1.0  initial release
// ============================================================================
package corefifo_pkg;

  localparam int OPCODE_W   = 38;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } fifo_op_t;

  typedef logic [OPCODE_W-1:0] opcode_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Picks the first requester at or after
//                the rotating pointer, wrapping N-1 -> 0. The pointer moves to
//                one past the winner only when the caller consumes the grant.
//  Ports       : clk     in  1      clock, posedge
//                rst     in  1      synchronous active-high reset (ptr -> 0)
//                req     in  N      request vector
//                advance in  1      grant consumed this cycle
//                gnt     out N      one-hot winner (zero when no request)
//                idx     out IDX_W  binary index of the winner
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic             hit_hi;
  logic             hit_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Two-pass priority: the lowest requester at or above the pointer wins;
  // if there is none, wrap around to the lowest requester overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_lo = 1'b1;
        idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr_q) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end
      end
    end
    idx = hit_hi ? idx_hi : idx_lo;
    gnt = hit_lo ? (N'(1) << idx) : '0;

    rr_ptr_d = rr_ptr_q;
    if (advance && hit_lo) begin
      rr_ptr_d = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/corefifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : corefifo_sched
//  Description : Access scheduler for the 4-deep core opcode FIFO. Arbitrates
//                NUM_SRC producers onto the write port and drains the read
//                port into a one-entry valid/ready output. At most one FIFO
//                operation per cycle; contention alternates read/write.
//  Ports       : clk, rst              clock / sync active-high reset
//                src_req   [NUM_SRC]   producer requests
//                src_data  [NUM_SRC*OP_W] producer opcodes, slice i*OP_W
//                src_gnt   [NUM_SRC]   one-hot grant, only on write cycles
//                fifo_w_enable/data    FIFO write port
//                fifo_r_enable         FIFO read strobe
//                fifo_r_data           FIFO registered read data
//                fifo_empty/full       FIFO registered flags
//                out_valid/out_data    opcode toward the raster core
//                out_ready             downstream accept
//  Revision    : 1.0  initial release
// ============================================================================
module corefifo_sched
  import corefifo_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int OP_W    = OPCODE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_req,
  input  logic [NUM_SRC*OP_W-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_gnt,
  output logic                    fifo_w_enable,
  output logic [OP_W-1:0]         fifo_w_data,
  output logic                    fifo_r_enable,
  input  logic [OP_W-1:0]         fifo_r_data,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  output logic                    out_valid,
  output logic [OP_W-1:0]         out_data,
  input  logic                    out_ready
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  fifo_op_t         last_op_q;
  fifo_op_t         last_op_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             can_wr;
  logic             can_rd;
  logic             do_wr;
  logic             do_rd;
  logic [NUM_SRC-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [OP_W-1:0]    src_arr [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_arr[gi] = src_data[gi*OP_W +: OP_W];
  end

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (src_req),
    .advance (do_wr),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // Op select. The FIFO flags are registered and already reflect last
  // cycle's op, so no local occupancy count is needed to avoid over/underflow.
  always_comb begin
    can_wr = (|src_req) & ~fifo_full;
    can_rd = ~fifo_empty & (~out_valid_q | out_ready);
    do_wr  = 1'b0;
    do_rd  = 1'b0;
    if (!rst) begin
      if (can_wr && can_rd) begin
        // Contention: strict alternation so neither side starves.
        do_wr = (last_op_q == OP_READ);
        do_rd = (last_op_q == OP_WRITE);
      end else begin
        do_wr = can_wr;
        do_rd = can_rd;
      end
    end

    last_op_d = last_op_q;
    if (do_wr) begin
      last_op_d = OP_WRITE;
    end else if (do_rd) begin
      last_op_d = OP_READ;
    end

    // A read refills the slot even while the current word is being accepted,
    // which gives back-to-back delivery.
    out_valid_d = out_valid_q;
    if (do_rd) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      last_op_q   <= OP_READ;
    end else begin
      out_valid_q <= out_valid_d;
      last_op_q   <= last_op_d;
    end
  end

  assign src_gnt       = do_wr ? arb_gnt : '0;
  assign fifo_w_enable = do_wr;
  assign fifo_w_data   = src_arr[arb_idx];
  assign fifo_r_enable = do_rd;
  assign out_valid     = out_valid_q;
  assign out_data      = fifo_r_data;

endmodule
`default_nettype wire
